// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU with 1-cycle logic/arith ops and iterative unsigned multiply/divide.
// Optional signed MULH/DIV/REM on opcodes 11xx when ALU_MDU_SIGNED_EN is defined.
module alu_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  DivZero
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t r_state, w_next_state;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [3:0]           r_op;
  logic [W-1:0]         r_hi, r_lo, r_b;
  logic [W:0]           w_add, w_sub, w_madd, w_dt, w_dsub;
  logic                 w_add_ovf, w_sub_ovf, w_borrow, w_op_mul;
  logic [W-1:0]         w_acc_res, w_ld_a, w_ld_b, w_it_hi, w_it_lo, w_fin_res;
  logic                 w_acc_ovf, w_acc_cout, w_acc_dz, w_acc_iter, w_fin_ovf;
`ifdef ALU_MDU_SIGNED_EN
  logic                 r_neg, r_sovf;
  logic [W-1:0]         w_mag_a, w_mag_b;
  assign w_mag_a = A[W-1] ? -A : A;
  assign w_mag_b = B[W-1] ? -B : B;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  assign w_add     = {1'b0, A} + {1'b0, B};
  assign w_sub     = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
  assign w_borrow  = ~w_sub[W];
  assign w_add_ovf = (A[W-1] == B[W-1]) && (w_add[W-1] != A[W-1]);
  assign w_sub_ovf = (A[W-1] != B[W-1]) && (w_sub[W-1] != A[W-1]);

  // Decode of the request presented in IDLE: immediate result or iterative load
  always_comb begin
    w_acc_res  = A & B;
    w_acc_ovf  = 1'b0;
    w_acc_cout = 1'b0;
    w_acc_dz   = 1'b0;
    w_acc_iter = 1'b0;
    w_ld_a     = A;
    w_ld_b     = B;
    case (ALUop)
      4'b0000: w_acc_res = A & B;
      4'b0001: w_acc_res = A | B;
      4'b0010: begin
        w_acc_res  = w_add[W-1:0];
        w_acc_ovf  = w_add_ovf;
        w_acc_cout = w_add[W];
      end
      4'b0011: w_acc_res = {{(W-1){1'b0}}, w_borrow};
      4'b0100: w_acc_res = A ^ B;
      4'b0101: w_acc_res = ~(A | B);
      4'b0110: begin
        w_acc_res  = w_sub[W-1:0];
        w_acc_ovf  = w_sub_ovf;
        w_acc_cout = w_borrow;
      end
      4'b0111: w_acc_res = {{(W-1){1'b0}}, w_sub[W-1] ^ w_sub_ovf};
      4'b1000, 4'b1001: w_acc_iter = 1'b1;
      4'b1010, 4'b1011: begin
        if (B == {W{1'b0}}) begin
          w_acc_res = ALUop[0] ? A : {W{1'b1}};
          w_acc_dz  = 1'b1;
        end else begin
          w_acc_iter = 1'b1;
        end
      end
`ifdef ALU_MDU_SIGNED_EN
      4'b1100: begin
        w_acc_iter = 1'b1;
        w_ld_a     = w_mag_a;
        w_ld_b     = w_mag_b;
      end
      4'b1101, 4'b1110: begin
        if (B == {W{1'b0}}) begin
          w_acc_res = ALUop[1] ? A : {W{1'b1}};
          w_acc_dz  = 1'b1;
        end else begin
          w_acc_iter = 1'b1;
          w_ld_a     = w_mag_a;
          w_ld_b     = w_mag_b;
        end
      end
`endif
      default: w_acc_res = A & B;
    endcase
  end

  // Shift-add multiply keeps the product in {r_hi,r_lo}; the divider keeps remainder/quotient there
  assign w_op_mul = (r_op == 4'b1000) || (r_op == 4'b1001) || (r_op == 4'b1100);
  assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
  assign w_dt     = {r_hi, r_lo[W-1]};
  assign w_dsub   = w_dt - {1'b0, r_b};

  // One multiply or restoring-divide step
  always_comb begin
    if (w_op_mul) begin
      w_it_hi = w_madd[W:1];
      w_it_lo = {w_madd[0], r_lo[W-1:1]};
    end else if (!w_dsub[W]) begin
      w_it_hi = w_dsub[W-1:0];
      w_it_lo = {r_lo[W-2:0], 1'b1};
    end else begin
      w_it_hi = w_dt[W-1:0];
      w_it_lo = {r_lo[W-2:0], 1'b0};
    end
  end

  // Result selection after the last step, with sign correction for signed ops
  always_comb begin
    w_fin_res = w_it_lo;
    w_fin_ovf = 1'b0;
    case (r_op)
      4'b1001, 4'b1011: w_fin_res = w_it_hi;
`ifdef ALU_MDU_SIGNED_EN
      4'b1100: w_fin_res = r_neg ? (~w_it_hi + {{(W-1){1'b0}}, (w_it_lo == {W{1'b0}})}) : w_it_hi;
      4'b1101: begin
        w_fin_res = r_neg ? -w_it_lo : w_it_lo;
        w_fin_ovf = r_sovf;
      end
      4'b1110: begin
        w_fin_res = r_neg ? -w_it_hi : w_it_hi;
        w_fin_ovf = r_sovf;
      end
`endif
      default: w_fin_res = w_it_lo;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next_state = w_acc_iter ? BUSY : DONE;
        else          w_next_state = IDLE;
      end
      BUSY: begin
        if (r_cnt == CNT_ONE) w_next_state = DONE;
        else                  w_next_state = BUSY;
      end
      DONE: begin
        if (out_ready) w_next_state = IDLE;
        else           w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand latch, iteration registers and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {CNT_WIDTH{1'b0}};
      r_op     <= 4'b0000;
      r_hi     <= {W{1'b0}};
      r_lo     <= {W{1'b0}};
      r_b      <= {W{1'b0}};
      Result   <= {W{1'b0}};
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Zero     <= 1'b1;
      DivZero  <= 1'b0;
`ifdef ALU_MDU_SIGNED_EN
      r_neg    <= 1'b0;
      r_sovf   <= 1'b0;
`endif
    end else if (r_state == IDLE && in_valid) begin
      r_op  <= ALUop;
      r_hi  <= {W{1'b0}};
      r_lo  <= w_ld_a;
      r_b   <= w_ld_b;
      r_cnt <= CNT_LOAD;
`ifdef ALU_MDU_SIGNED_EN
      r_neg  <= (ALUop == 4'b1110) ? A[W-1] : (A[W-1] ^ B[W-1]);
      r_sovf <= (A == {1'b1, {(W-1){1'b0}}}) && (B == {W{1'b1}});
`endif
      if (!w_acc_iter) begin
        Result   <= w_acc_res;
        Overflow <= w_acc_ovf;
        CarryOut <= w_acc_cout;
        Zero     <= (w_acc_res == {W{1'b0}});
        DivZero  <= w_acc_dz;
      end
    end else if (r_state == BUSY) begin
      r_hi  <= w_it_hi;
      r_lo  <= w_it_lo;
      r_cnt <= r_cnt - CNT_ONE;
      if (r_cnt == CNT_ONE) begin
        Result   <= w_fin_res;
        Overflow <= w_fin_ovf;
        CarryOut <= 1'b0;
        Zero     <= (w_fin_res == {W{1'b0}});
        DivZero  <= 1'b0;
      end
    end
  end
endmodule
